// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: the stage-state encoding and a
// reference control-field layout that users may pack into CTRL_W.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       branch;
      logic       jump;
      logic [3:0] alu_ctrl;
      logic [6:0] rsvd;
   } stage_ctrl_t;

   localparam int STAGE_CTRL_W = $bits(stage_ctrl_t);

   // Number of held entries implied by a stage state.
   function automatic logic [1:0] occupancy_of(input stage_state_e s);
      case (s)
         ST_ONE:  return 2'd1;
         ST_TWO:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear, else increment unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !(&cnt_q)) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, out_valid low
//   ST_ONE   | main register holds the head entry
//   ST_TWO   | main and skid both full (only when SKID != 0)
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 16,
   parameter int SKID   = 1,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   stage_state_e      state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              accept;
   logic              rel;

   // With the skid buffer, in_ready comes from state only so no ready chain
   // forms; without it, a full stage may still accept when the head leaves.
   if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state_q != ST_TWO);
   end else begin : g_single_ready
      assign in_ready = (state_q == ST_EMPTY) || out_ready;
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_data_q;
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign occupancy = occupancy_of(state_q);

   assign accept = in_valid && in_ready;
   assign rel    = out_valid && out_ready;

   // Next-state and payload selection; flush overrides everything and only
   // zeroes the ctrl fields, data registers keep their contents.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d     = ST_ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            ST_ONE: begin
               if (accept && rel) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (accept && (SKID != 0)) begin
                  state_d     = ST_TWO;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (rel) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (rel) begin
                  state_d     = ST_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and payload registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (stall_clr),
      .inc (out_valid && !out_ready && !flush),
      .q   (stall_cnt)
   );

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake, optional 2-entry skid buffer, synchronous flush and a saturating stall counter. It replaces fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) so that back-pressure from a slow stage can propagate without combinational ready chains. Control fields are zeroed whenever the stage holds no valid entry, so a downstream stage always sees a clean bubble.

## Interface
- DATA_W, 64: width of the datapath payload (operands, PC, immediate, register indices).
- CTRL_W, 16: width of the control payload (RegWrite, MemWrite, ALU control, branch/jump and similar fields).
- SKID, 1: 1 selects 2-entry skid buffer with registered in_ready; 0 selects a single entry with in_ready = !full || out_ready.
- CNT_W, 32: width of the stall counter.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of every held entry (branch mispredict or trap).
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  entry available to the downstream stage.
- out_ready  in  1  downstream accepts an entry this cycle.
- out_data  out  DATA_W  head-entry datapath payload.
- out_ctrl  out  CTRL_W  head-entry control payload; all-zero when out_valid = 0.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturates at all-ones.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Accept = in_valid && in_ready. Release = out_valid && out_ready.
- States (shared enum): EMPTY, ONE (main register holds the head), TWO (main and skid both full; SKID=1 only).
- EMPTY: accept -> ONE, main <= in.
- ONE: accept && !release -> TWO, skid <= in. !accept && release -> EMPTY. accept && release -> ONE, main <= in.
- TWO: release -> ONE, main <= skid. Accept is impossible because in_ready = 0.
- SKID=1: in_ready = (state != TWO), decoded from a register only; no path from out_ready.
- SKID=0: state TWO is unreachable; in_ready = (state == EMPTY) || out_ready, a combinational path.
- out_valid = (state != EMPTY). out_data = main data. out_ctrl = main ctrl when valid, otherwise 0.
- Flush has the highest priority. The next state is EMPTY, and the main and skid ctrl fields are zeroed. An in_valid arriving in the flush cycle is dropped even if in_ready = 1. Data registers keep their values.
- stall_cnt: stall_clr has priority and loads 0. Otherwise it increments on out_valid && !out_ready && !flush and holds at 2^CNT_W-1.
- occupancy encodes the state: 0, 1 or 2.

## Timing
- Reset values: state EMPTY, out_valid 0, out_ctrl 0, out_data 0, occupancy 0, stall_cnt 0, in_ready 1 (both modes).
- Latency: an accept in cycle N gives out_valid = 1 in cycle N+1 with the accepted payload. There is no combinational in-to-out path.
- Throughput: 1 entry per cycle while out_ready is held high, in both modes.
- SKID=1 back-pressure: out_ready falling in cycle N means the in_ready fall is seen in N+1 at the earliest. The skid absorbs the one entry accepted in cycle N.
- Ordering: strictly FIFO. The skid entry is never released before the main entry.
- Reset asserted mid-operation: all entries are discarded immediately and no partial entry is released after deassert.
- Flush together with release: the downstream consumes the entry in that cycle, and the stage is EMPTY in the next cycle.

## Structure
- The package pipe_pkg holds the stage-state enum (EMPTY, ONE, TWO) and a reusable ctrl struct typedef. Users may pack their ctrl struct into CTRL_W.
- The stall counter is a natural sub-module: sat_counter (parameter W; ports clr, inc, q).
- Expected RTL size: about 150-250 lines including the sat_counter.

## Test plan
- Reset during traffic (state TWO): rst high -> in the same cycle out_valid 0, out_ctrl 0, occupancy 0; in_ready 1 after deassert.
- Streaming with SKID=1 and out_ready=1: feed in_data 1..8 over 8 cycles -> out_data 1..8 in cycles 2..9, occupancy stays 1, stall_cnt 0.
- Back-pressure with SKID=1: out_ready low from cycle 3 while streaming -> skid captures the entry accepted in cycle 3, in_ready low from cycle 4, occupancy 2. Raising out_ready releases the entries in order with none lost or duplicated.
- Flush with two held entries plus in_valid high: flush for one cycle -> next cycle out_valid 0, out_ctrl 0, occupancy 0, and the incoming entry is absent from the output.
- SKID=0 with out_ready toggling every cycle: in_ready follows (state==EMPTY)||out_ready each cycle and occupancy never exceeds 1.
- Stall counter with CNT_W=4 and out_valid held high with out_ready low for 20 cycles -> stall_cnt saturates at 15. stall_clr pulse -> 0 in the next cycle.
